// File: rtl/tank_game_sequencer.sv
`default_nettype none
// tank_game_sequencer: screen-flow FSM, per-tank lives and timed per-player bullet enables.
// Optional macro TANK_SEQ_AUTOSTART_EN: WELCOME also advances to PLAY after WIN_TICKS ticks.
module tank_game_sequencer #(
    parameter int LIVES          = 3,
    parameter int PAUSE_TICKS    = 60,
    parameter int WIN_TICKS      = 180,
    parameter int BULLET_TICKS   = 30,
    parameter int COOLDOWN_TICKS = 20
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tick_i,
    input  logic       start_i,
    input  logic [1:0] hit_i,
    input  logic [1:0] fire_req_i,
    output logic [3:0] frame_o,
    output logic [1:0] bullet_o,
    output logic [2:0] lives1_o,
    output logic [2:0] lives2_o,
    output logic       state_irq_o
);
    localparam int         CW      = 16;
    localparam logic [2:0] C_LIVES = 3'(LIVES);

    typedef enum logic [2:0] {
        S_WELCOME = 3'd0,
        S_PLAY    = 3'd1,
        S_PAUSE   = 3'd2,
        S_WIN1    = 3'd3,
        S_WIN2    = 3'd4,
        S_DRAW    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_SHOT = 2'd1,
        F_COOL = 2'd2
    } fire_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_limit;
    logic            r_start_d;
    logic [1:0]      r_hit_d, r_fire_d;
    logic            w_start_edge;
    logic [1:0]      w_hit_edge, w_fire_edge;
    logic [2:0]      w_lives1_nxt, w_lives2_nxt;
    logic [3:0]      w_frame_nxt;
    logic            w_cnt_done;
    logic            w_fire_en;

    assign w_start_edge = start_i & ~r_start_d;
    assign w_hit_edge   = hit_i & ~r_hit_d;
    assign w_fire_edge  = fire_req_i & ~r_fire_d;

    // Timed states share one counter; it restarts whenever the state changes.
    always_comb begin
        w_cnt_limit = CW'(WIN_TICKS - 1);
        if (r_state == S_PAUSE)
            w_cnt_limit = CW'(PAUSE_TICKS - 1);
    end
    assign w_cnt_done = tick_i && (r_cnt == w_cnt_limit);

    always_comb begin
        w_state_nxt  = r_state;
        w_lives1_nxt = lives1_o;
        w_lives2_nxt = lives2_o;
        case (r_state)
            S_WELCOME: begin
                w_lives1_nxt = C_LIVES;
                w_lives2_nxt = C_LIVES;
`ifdef TANK_SEQ_AUTOSTART_EN
                if (w_start_edge || w_cnt_done)
                    w_state_nxt = S_PLAY;
`else
                if (w_start_edge)
                    w_state_nxt = S_PLAY;
`endif
            end
            S_PLAY: begin
                if (|w_hit_edge) begin
                    if (w_hit_edge[0] && (lives1_o != 3'd0))
                        w_lives1_nxt = lives1_o - 3'd1;
                    if (w_hit_edge[1] && (lives2_o != 3'd0))
                        w_lives2_nxt = lives2_o - 3'd1;
                    if ((w_lives1_nxt == 3'd0) && (w_lives2_nxt == 3'd0))
                        w_state_nxt = S_DRAW;
                    else if (w_lives1_nxt == 3'd0)
                        w_state_nxt = S_WIN2;
                    else if (w_lives2_nxt == 3'd0)
                        w_state_nxt = S_WIN1;
                    else
                        w_state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (w_cnt_done)
                    w_state_nxt = S_PLAY;
            end
            S_WIN1, S_WIN2, S_DRAW: begin
                if (w_cnt_done) begin
                    w_state_nxt  = S_WELCOME;
                    w_lives1_nxt = C_LIVES;
                    w_lives2_nxt = C_LIVES;
                end
            end
            default: w_state_nxt = S_WELCOME;
        endcase
    end

    always_comb begin
        case (w_state_nxt)
            S_PLAY, S_PAUSE: w_frame_nxt = 4'b0001;
            S_WIN1:          w_frame_nxt = 4'b0100;
            S_WIN2:          w_frame_nxt = 4'b1000;
            S_DRAW:          w_frame_nxt = 4'b1100;
            default:         w_frame_nxt = 4'b0010;
        endcase
    end

    // Edge registers reset high so a level held through reset is not an edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_WELCOME;
            r_cnt       <= '0;
            r_start_d   <= 1'b1;
            r_hit_d     <= 2'b11;
            r_fire_d    <= 2'b11;
            frame_o     <= 4'b0010;
            lives1_o    <= C_LIVES;
            lives2_o    <= C_LIVES;
            state_irq_o <= 1'b0;
        end else begin
            r_start_d   <= start_i;
            r_hit_d     <= hit_i;
            r_fire_d    <= fire_req_i;
            r_state     <= w_state_nxt;
            frame_o     <= w_frame_nxt;
            lives1_o    <= w_lives1_nxt;
            lives2_o    <= w_lives2_nxt;
            state_irq_o <= (w_state_nxt != r_state);
            if (w_state_nxt != r_state)
                r_cnt <= '0;
            else if (tick_i)
                r_cnt <= r_cnt + CW'(1);
        end
    end

    // Channels run only while staying in PLAY; any exit clears them on the same edge.
    assign w_fire_en = (r_state == S_PLAY) && (w_state_nxt == S_PLAY);

    generate
        for (genvar k = 0; k < 2; k++) begin : g_fire
            fire_t         r_ch, w_ch_nxt;
            logic [CW-1:0] r_fcnt, w_fcnt_nxt;
            logic          r_bullet, w_bullet_nxt;

            always_comb begin
                w_ch_nxt     = r_ch;
                w_fcnt_nxt   = r_fcnt;
                w_bullet_nxt = r_bullet;
                if (!w_fire_en) begin
                    w_ch_nxt     = F_IDLE;
                    w_fcnt_nxt   = '0;
                    w_bullet_nxt = 1'b0;
                end else begin
                    case (r_ch)
                        F_IDLE: begin
                            if (w_fire_edge[k]) begin
                                w_ch_nxt     = F_SHOT;
                                w_fcnt_nxt   = '0;
                                w_bullet_nxt = 1'b1;
                            end
                        end
                        F_SHOT: begin
                            if (tick_i) begin
                                if (r_fcnt == CW'(BULLET_TICKS - 1)) begin
                                    w_ch_nxt     = F_COOL;
                                    w_fcnt_nxt   = '0;
                                    w_bullet_nxt = 1'b0;
                                end else begin
                                    w_fcnt_nxt = r_fcnt + CW'(1);
                                end
                            end
                        end
                        F_COOL: begin
                            if (tick_i) begin
                                if (r_fcnt == CW'(COOLDOWN_TICKS - 1)) begin
                                    w_ch_nxt   = F_IDLE;
                                    w_fcnt_nxt = '0;
                                end else begin
                                    w_fcnt_nxt = r_fcnt + CW'(1);
                                end
                            end
                        end
                        default: begin
                            w_ch_nxt     = F_IDLE;
                            w_fcnt_nxt   = '0;
                            w_bullet_nxt = 1'b0;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_ch     <= F_IDLE;
                    r_fcnt   <= '0;
                    r_bullet <= 1'b0;
                end else begin
                    r_ch     <= w_ch_nxt;
                    r_fcnt   <= w_fcnt_nxt;
                    r_bullet <= w_bullet_nxt;
                end
            end

            assign bullet_o[k] = r_bullet;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tank_game_sequencer.sv
`default_nettype none
// Bench for tank_game_sequencer: game-flow vector table plus fire-timing and async-reset sequences.
module tb_tank_game_sequencer;
    logic       clk = 1'b0;
    logic       rstn;
    logic       tick_i;
    logic       start_i;
    logic [1:0] hit_i;
    logic [1:0] fire_req_i;
    logic [3:0] frame_o;
    logic [1:0] bullet_o;
    logic [2:0] lives1_o;
    logic [2:0] lives2_o;
    logic       state_irq_o;

    int checks = 0;
    int errors = 0;
    int irq_cnt = 0;

    typedef struct {
        logic       st;
        logic [1:0] hit;
        logic [1:0] fire;
        int         ticks;
        logic [3:0] frame;
        int         l1;
        int         l2;
        logic [1:0] bul;
        int         irq;
    } vec_t;

    vec_t tbl[28];

    always #5 clk = ~clk;

    tank_game_sequencer dut (
        .clk         (clk),
        .rstn        (rstn),
        .tick_i      (tick_i),
        .start_i     (start_i),
        .hit_i       (hit_i),
        .fire_req_i  (fire_req_i),
        .frame_o     (frame_o),
        .bullet_o    (bullet_o),
        .lives1_o    (lives1_o),
        .lives2_o    (lives2_o),
        .state_irq_o (state_irq_o)
    );

    always @(negedge clk) if (state_irq_o === 1'b1) irq_cnt++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_ticks(input int n);
        for (int t = 0; t < n; t++) begin
            tick_i = 1'b1;
            @(negedge clk);
            tick_i = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pulse_fire(input logic [1:0] f);
        fire_req_i = f;
        step();
        fire_req_i = 2'b00;
        step();
    endtask

    initial begin
        //          st   hit    fire   t    frame    l1 l2 bul    irq
        tbl[0]  = '{1'b1, 2'b11, 2'b00, 0,   4'b0010, 3, 3, 2'b00, 0};
        tbl[1]  = '{1'b0, 2'b00, 2'b00, 0,   4'b0010, 3, 3, 2'b00, 0};
        tbl[2]  = '{1'b1, 2'b00, 2'b00, 0,   4'b0001, 3, 3, 2'b00, 1};
        tbl[3]  = '{1'b0, 2'b10, 2'b00, 0,   4'b0001, 3, 2, 2'b00, 2};
        tbl[4]  = '{1'b0, 2'b00, 2'b00, 10,  4'b0001, 3, 2, 2'b00, 2};
        tbl[5]  = '{1'b0, 2'b10, 2'b01, 0,   4'b0001, 3, 2, 2'b00, 2};
        tbl[6]  = '{1'b0, 2'b00, 2'b00, 49,  4'b0001, 3, 2, 2'b00, 2};
        tbl[7]  = '{1'b0, 2'b00, 2'b00, 1,   4'b0001, 3, 2, 2'b00, 3};
        tbl[8]  = '{1'b0, 2'b10, 2'b00, 0,   4'b0001, 3, 1, 2'b00, 4};
        tbl[9]  = '{1'b0, 2'b00, 2'b00, 60,  4'b0001, 3, 1, 2'b00, 5};
        tbl[10] = '{1'b0, 2'b10, 2'b00, 0,   4'b0100, 3, 0, 2'b00, 6};
        tbl[11] = '{1'b1, 2'b00, 2'b00, 0,   4'b0100, 3, 0, 2'b00, 6};
        tbl[12] = '{1'b0, 2'b00, 2'b00, 179, 4'b0100, 3, 0, 2'b00, 6};
        tbl[13] = '{1'b0, 2'b00, 2'b00, 1,   4'b0010, 3, 3, 2'b00, 7};
        tbl[14] = '{1'b1, 2'b00, 2'b00, 0,   4'b0001, 3, 3, 2'b00, 8};
        tbl[15] = '{1'b0, 2'b11, 2'b00, 0,   4'b0001, 2, 2, 2'b00, 9};
        tbl[16] = '{1'b0, 2'b00, 2'b00, 60,  4'b0001, 2, 2, 2'b00, 10};
        tbl[17] = '{1'b0, 2'b11, 2'b00, 0,   4'b0001, 1, 1, 2'b00, 11};
        tbl[18] = '{1'b0, 2'b00, 2'b00, 60,  4'b0001, 1, 1, 2'b00, 12};
        tbl[19] = '{1'b0, 2'b11, 2'b00, 0,   4'b1100, 0, 0, 2'b00, 13};
        tbl[20] = '{1'b0, 2'b00, 2'b00, 180, 4'b0010, 3, 3, 2'b00, 14};
        tbl[21] = '{1'b1, 2'b00, 2'b00, 0,   4'b0001, 3, 3, 2'b00, 15};
        tbl[22] = '{1'b0, 2'b01, 2'b00, 0,   4'b0001, 2, 3, 2'b00, 16};
        tbl[23] = '{1'b0, 2'b00, 2'b00, 60,  4'b0001, 2, 3, 2'b00, 17};
        tbl[24] = '{1'b0, 2'b01, 2'b00, 0,   4'b0001, 1, 3, 2'b00, 18};
        tbl[25] = '{1'b0, 2'b00, 2'b00, 60,  4'b0001, 1, 3, 2'b00, 19};
        tbl[26] = '{1'b0, 2'b01, 2'b00, 0,   4'b1000, 0, 3, 2'b00, 20};
        tbl[27] = '{1'b0, 2'b00, 2'b00, 180, 4'b0010, 3, 3, 2'b00, 21};

        // Reset with start and both hits held high.
        rstn = 1'b0; tick_i = 1'b0; start_i = 1'b1; hit_i = 2'b11; fire_req_i = 2'b00;
        repeat (3) step();
        #1;
        chk("in_reset frame", 32'(frame_o), 32'h2);
        chk("in_reset bullet", 32'(bullet_o), 32'h0);
        rstn = 1'b1;
        repeat (2) step();
        #1;
        chk("post_reset frame", 32'(frame_o), 32'h2);
        chk("post_reset lives1", 32'(lives1_o), 32'd3);
        chk("post_reset lives2", 32'(lives2_o), 32'd3);
        chk("post_reset irq count", 32'(irq_cnt), 32'd0);

        for (int i = 0; i < 28; i++) begin
            start_i    = tbl[i].st;
            hit_i      = tbl[i].hit;
            fire_req_i = tbl[i].fire;
            step();
            do_ticks(tbl[i].ticks);
            #1;
            chk($sformatf("row%0d frame", i), 32'(frame_o), 32'(tbl[i].frame));
            chk($sformatf("row%0d lives1", i), 32'(lives1_o), 32'(tbl[i].l1));
            chk($sformatf("row%0d lives2", i), 32'(lives2_o), 32'(tbl[i].l2));
            chk($sformatf("row%0d bullet", i), 32'(bullet_o), 32'(tbl[i].bul));
            chk($sformatf("row%0d irq count", i), 32'(irq_cnt), 32'(tbl[i].irq));
        end

        // Fire channel 0 timing: shot, drops in SHOT and COOL, refire after cooldown.
        start_i = 1'b1; step(); start_i = 1'b0;
        #1; chk("fire play frame", 32'(frame_o), 32'h1);
        fire_req_i = 2'b01; step(); fire_req_i = 2'b00;
        #1; chk("fire0 shot starts", 32'(bullet_o), 32'h1);
        do_ticks(5);
        pulse_fire(2'b01);
        #1; chk("fire0 edge in shot", 32'(bullet_o), 32'h1);
        do_ticks(24);
        #1; chk("fire0 tick29 on", 32'(bullet_o), 32'h1);
        do_ticks(1);
        #1; chk("fire0 tick30 off", 32'(bullet_o), 32'h0);
        do_ticks(10);
        pulse_fire(2'b01);
        #1; chk("fire0 edge tick40 dropped", 32'(bullet_o), 32'h0);
        do_ticks(9);
        pulse_fire(2'b01);
        #1; chk("fire0 edge tick49 dropped", 32'(bullet_o), 32'h0);
        do_ticks(2);
        fire_req_i = 2'b01; step(); fire_req_i = 2'b00;
        #1; chk("fire0 edge tick51 fires", 32'(bullet_o), 32'h1);
        fire_req_i = 2'b10; step(); fire_req_i = 2'b00;
        #1; chk("fire1 independent", 32'(bullet_o), 32'h3);

        // Hit while shooting: leaving PLAY clears bullets on the same edge.
        hit_i = 2'b10; step();
        #1;
        chk("pause bullets cleared", 32'(bullet_o), 32'h0);
        chk("pause irq pulse", 32'(state_irq_o), 32'h1);
        chk("pause lives2", 32'(lives2_o), 32'd2);
        hit_i = 2'b00; step();
        #1; chk("irq single cycle", 32'(state_irq_o), 32'h0);
        do_ticks(60);
        hit_i = 2'b11; step(); hit_i = 2'b00;
        do_ticks(60);
        fire_req_i = 2'b01; step(); fire_req_i = 2'b00;
        #1;
        chk("pre_rst lives1", 32'(lives1_o), 32'd2);
        chk("pre_rst lives2", 32'(lives2_o), 32'd1);
        chk("pre_rst bullet", 32'(bullet_o), 32'h1);
        do_ticks(3);

        // Asynchronous reset mid-shot, checked before any clock edge.
        #2 rstn = 1'b0;
        #1;
        chk("async_rst frame", 32'(frame_o), 32'h2);
        chk("async_rst bullet", 32'(bullet_o), 32'h0);
        chk("async_rst lives1", 32'(lives1_o), 32'd3);
        chk("async_rst lives2", 32'(lives2_o), 32'd3);
        chk("async_rst irq", 32'(state_irq_o), 32'h0);
        step();
        rstn = 1'b1;
        repeat (3) step();
        #1; chk("after_rst welcome", 32'(frame_o), 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
